// File: rtl/button_conditioner.sv
// Button front end: source merge, 2-flop sync, debounce, and
// press/release/auto-repeat/toggle event generation per channel.
module button_conditioner #(
  parameter int N_BTN         = 8,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] bt_wired,
  input  logic [N_BTN-1:0] bt_wireless,
  input  logic             wired_en,
  input  logic             wireless_en,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_toggle,
  output logic             btn_any
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] lvl_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] rel_d;
  logic [N_BTN-1:0] rep_d;
  logic [N_BTN-1:0] act_q;
  logic [N_BTN-1:0] act_d;
  logic [CNT_W-1:0] db_q [N_BTN];
  logic [CNT_W-1:0] db_d [N_BTN];
  logic [CNT_W-1:0] rc_q [N_BTN];
  logic [CNT_W-1:0] rc_d [N_BTN];

  assign raw = (bt_wired & {N_BTN{wired_en}})
             | (bt_wireless & {N_BTN{wireless_en}});

  always_comb begin
    lvl_d = btn_level;
    rep_d = '0;
    act_d = act_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_d[i] = '0;
      rc_d[i] = rc_q[i];
      if (s2[i] != btn_level[i]) begin
        if (db_q[i] == DB_LAST) lvl_d[i] = s2[i];
        else db_d[i] = db_q[i] + ONE;
      end
    end
    press_d = lvl_d & ~btn_level;
    rel_d   = ~lvl_d & btn_level;
    // act marks a running repeat schedule; a fresh enable reloads the delay
    for (int i = 0; i < N_BTN; i++) begin
      unique case (1'b1)
        press_d[i]: begin
          rc_d[i]  = RD_LOAD;
          act_d[i] = 1'b1;
        end
        btn_level[i] & lvl_d[i] & repeat_en[i]: begin
          if (!act_q[i]) begin
            rc_d[i]  = RD_LOAD;
            act_d[i] = 1'b1;
          end else if (rc_q[i] == '0) begin
            rep_d[i] = 1'b1;
            rc_d[i]  = RP_LOAD;
          end else begin
            rc_d[i] = rc_q[i] - ONE;
          end
        end
        default: begin
          rc_d[i]  = '0;
          act_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      btn_toggle  <= '0;
      btn_any     <= 1'b0;
      act_q       <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_q[i] <= '0;
        rc_q[i] <= '0;
      end
    end else begin
      s1          <= raw;
      s2          <= s1;
      btn_level   <= lvl_d;
      btn_press   <= press_d;
      btn_release <= rel_d;
      btn_repeat  <= rep_d;
      btn_toggle  <= btn_toggle ^ press_d;
      btn_any     <= |lvl_d;
      act_q       <= act_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_q[i] <= db_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, directed corner
// sequences and random traffic against a time-based reference model.
module tb_button_conditioner;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int CW = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] bt_wired = '0;
  logic [N-1:0] bt_wireless = '0;
  logic         wired_en = 1'b1;
  logic         wireless_en = 1'b1;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic [N-1:0] btn_toggle;
  logic         btn_any;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .bt_wired(bt_wired), .bt_wireless(bt_wireless),
    .wired_en(wired_en), .wireless_en(wireless_en),
    .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat),
    .btn_toggle(btn_toggle), .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;

  // reference model: raw delay line, window of synchronised samples,
  // and elapsed edges since each channel's repeat reference point
  logic [N-1:0] d1 = '0, d2 = '0;
  logic [N-1:0] hist [$];
  logic [N-1:0] m_lvl = '0, m_prs = '0, m_rel = '0;
  logic [N-1:0] m_rep = '0, m_tog = '0;
  logic         m_any = 1'b0;
  int           since [N];
  bit           armed [N];

  task automatic model_edge();
    logic [N-1:0] raw, nl, rep;
    bit all_diff;
    if (rst) begin
      d1 = '0; d2 = '0; hist.delete();
      m_lvl = '0; m_prs = '0; m_rel = '0;
      m_rep = '0; m_tog = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        since[i] = 0; armed[i] = 1'b0;
      end
    end else begin
      raw = (bt_wired & {N{wired_en}}) | (bt_wireless & {N{wireless_en}});
      hist.push_back(d2);
      if (hist.size() > DB) hist.delete(0);
      d2 = d1;
      d1 = raw;
      nl = m_lvl;
      for (int i = 0; i < N; i++) begin
        if (hist.size() == DB) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++)
            if (hist[j][i] == m_lvl[i]) all_diff = 1'b0;
          if (all_diff) nl[i] = ~m_lvl[i];
        end
      end
      rep = '0;
      for (int i = 0; i < N; i++) begin
        if (nl[i] && !m_lvl[i]) begin
          since[i] = 0; armed[i] = 1'b1;
        end else if (m_lvl[i] && nl[i] && repeat_en[i]) begin
          if (!armed[i]) begin
            armed[i] = 1'b1; since[i] = 0;
          end else begin
            since[i]++;
            if (since[i] >= RD && (since[i] - RD) % RP == 0) rep[i] = 1'b1;
          end
        end else begin
          armed[i] = 1'b0; since[i] = 0;
        end
      end
      m_prs = nl & ~m_lvl;
      m_rel = ~nl & m_lvl;
      m_tog = m_tog ^ m_prs;
      m_lvl = nl;
      m_any = |nl;
      m_rep = rep;
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    vecs++;
    if (btn_level !== m_lvl || btn_press !== m_prs ||
        btn_release !== m_rel || btn_repeat !== m_rep ||
        btn_toggle !== m_tog || btn_any !== m_any) begin
      miss++;
      $display("FAIL %s cyc=%0d lvl=%h exp %h prs=%h exp %h rel=%h exp %h rep=%h exp %h tog=%h exp %h any=%b exp %b",
               name, cyc, btn_level, m_lvl, btn_press, m_prs,
               btn_release, m_rel, btn_repeat, m_rep,
               btn_toggle, m_tog, btn_any, m_any);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         w0;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] tog;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int press_at, first_at, nrep, rel_seen, seen;

    // basic press/release of wired channel 0
    for (int k = 0; k < 14; k++) begin
      tbl[k].w0  = (k < 7);
      tbl[k].lvl = (k >= 5 && k < 12) ? 8'h01 : 8'h00;
      tbl[k].prs = (k == 5) ? 8'h01 : 8'h00;
      tbl[k].rel = (k == 12) ? 8'h01 : 8'h00;
      tbl[k].tog = (k >= 5) ? 8'h01 : 8'h00;
    end

    // test 1: reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bt_wired = N'($urandom); bt_wireless = N'($urandom);
      repeat_en = N'($urandom);
      step("reset");
      chk("reset_zero",
          {btn_level, btn_press, btn_release, btn_repeat, btn_toggle, 7'd0, btn_any},
          64'd0);
    end
    rst = 1'b0; bt_wired = '0; bt_wireless = '0; repeat_en = '0;
    wired_en = 1'b1; wireless_en = 1'b1;
    for (int k = 0; k < 6; k++) step("idle");
    chk("idle_zero", {32'd0, btn_level, btn_toggle, 7'd0, btn_any, 8'd0}, 64'd0);

    // test 2: table
    for (int k = 0; k < 14; k++) begin
      bt_wired = {7'd0, tbl[k].w0};
      step("tbl_model");
      chk($sformatf("tbl[%0d]", k),
          {24'd0, btn_level, btn_press, btn_release, btn_toggle, 7'd0, btn_any},
          {24'd0, tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].tog, 7'd0, |tbl[k].lvl});
    end

    // test 3: glitch vs valid pulse on wireless channel 2
    seen = 0;
    bt_wireless = 8'h04;
    for (int k = 0; k < 3; k++) step("glitch");
    bt_wireless = '0;
    for (int k = 0; k < 10; k++) begin
      step("glitch");
      if (btn_level[2] | btn_press[2]) seen = 1;
    end
    chk("glitch3_ignored", 64'(seen), 64'd0);
    seen = 0;
    bt_wireless = 8'h04;
    for (int k = 0; k < 4; k++) begin
      step("pulse4");
      if (btn_press[2]) seen = 1;
    end
    bt_wireless = '0;
    for (int k = 0; k < 12; k++) begin
      step("pulse4");
      if (btn_press[2]) seen = 1;
    end
    chk("pulse4_press", 64'(seen), 64'd1);

    // test 4: auto-repeat on channel 1
    repeat_en = 8'h02; bt_wired = 8'h02;
    press_at = -1; first_at = -1; nrep = 0; rel_seen = 0;
    for (int k = 0; k < 42; k++) begin
      if (k == 30) bt_wired = '0;
      step("repeat");
      if (btn_press[1]) press_at = k;
      if (btn_repeat[1]) begin
        nrep++;
        if (first_at < 0) first_at = k;
      end
      if (btn_release[1]) rel_seen++;
    end
    chk("rep_press_at", 64'(press_at), 64'd5);
    chk("rep_first_gap", 64'(first_at - press_at), 64'(RD));
    chk("rep_count", 64'(nrep), 64'd6);
    chk("rep_release", 64'(rel_seen), 64'd1);

    // test 5: wireless disabled, simultaneous wired presses
    repeat_en = '0; wireless_en = 1'b0; bt_wireless = 8'hFF;
    for (int k = 0; k < 10; k++) step("wl_off");
    chk("wl_off_level", 64'(btn_level), 64'd0);
    bt_wired = 8'h28;
    for (int k = 0; k < 6; k++) step("dual");
    chk("dual_press", {55'd0, btn_any, btn_press}, {55'd0, 1'b1, 8'h28});
    bt_wired = '0;
    for (int k = 0; k < 12; k++) step("dual_rel");

    // test 6: reset mid-hold during repeat
    wireless_en = 1'b1; bt_wireless = '0;
    repeat_en = 8'h10; bt_wired = 8'h10; seen = 0;
    for (int k = 0; k < 19; k++) begin
      step("hold4");
      if (btn_repeat[4]) seen = 1;
    end
    chk("hold4_repeat", 64'(seen), 64'd1);
    rst = 1'b1;
    step("rst_mid");
    chk("rst_mid_zero",
        {btn_level, btn_press, btn_release, btn_repeat, btn_toggle, 7'd0, btn_any},
        64'd0);
    rst = 1'b0; press_at = -1;
    for (int k = 1; k <= 9; k++) begin
      step("after_rst");
      if (btn_press[4] && press_at < 0) press_at = k;
    end
    chk("after_rst_press", 64'(press_at), 64'(DB + 2));
    chk("after_rst_tog", 64'(btn_toggle), 64'h10);

    // random traffic with slowly changing buttons and enables
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) bt_wired[i] = ~bt_wired[i];
        if ($urandom_range(0, 11) == 0) bt_wireless[i] = ~bt_wireless[i];
        if ($urandom_range(0, 40) == 0) repeat_en[i] = ~repeat_en[i];
      end
      if ($urandom_range(0, 99) == 0) wired_en = ~wired_en;
      if ($urandom_range(0, 99) == 0) wireless_en = ~wireless_en;
      rst = ($urandom_range(0, 299) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
